// File: rtl/seq_shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: captures an operand on start and shifts it up to STEP bits per clock.
// Supports SHR, SHRA, SHL, ROR and ROL; returns the result with a one-cycle done pulse.
module seq_shift_rotate_unit #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             Clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [2:0]       OP_SHR   = 3'd0;
    localparam logic [2:0]       OP_SHRA  = 3'd1;
    localparam logic [2:0]       OP_SHL   = 3'd2;
    localparam logic [2:0]       OP_ROR   = 3'd3;
    localparam logic [2:0]       OP_ROL   = 3'd4;
    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             carry_q, carry_d;

    logic [AMT_W-1:0] step_amt;
    logic [AMT_W-1:0] wrap_amt;

    // wrap_amt is WIDTH - step_amt, relying on AMT_W-bit arithmetic wrapping modulo WIDTH.
    always_comb begin
        step_amt = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
        wrap_amt = '0 - step_amt;
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        rem_d   = rem_q;
        carry_d = carry_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    work_d  = a;
                    op_d    = op;
                    rem_d   = amt;
                    carry_d = 1'b0;
                    if (amt == '0 || op > OP_ROL) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end

            BUSY: begin
                rem_d = rem_q - step_amt;
                // Right-moving ops lose bit step_amt-1 last; left-moving ops lose bit WIDTH-step_amt last.
                case (op_q)
                    OP_SHR: begin
                        work_d  = work_q >> step_amt;
                        carry_d = work_q[step_amt - AMT_W'(1)];
                    end
                    OP_SHRA: begin
                        work_d  = $unsigned($signed(work_q) >>> step_amt);
                        carry_d = work_q[step_amt - AMT_W'(1)];
                    end
                    OP_SHL: begin
                        work_d  = work_q << step_amt;
                        carry_d = work_q[wrap_amt];
                    end
                    OP_ROR: begin
                        work_d  = (work_q >> step_amt) | (work_q << wrap_amt);
                        carry_d = work_q[step_amt - AMT_W'(1)];
                    end
                    OP_ROL: begin
                        work_d  = (work_q << step_amt) | (work_q >> wrap_amt);
                        carry_d = work_q[wrap_amt];
                    end
                    default: begin
                        rem_d = '0;
                    end
                endcase
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            state_q <= IDLE;
            work_q  <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            carry_q <= carry_d;
        end
    end

    assign busy      = (state_q == BUSY);
    assign done      = (state_q == DONE);
    assign result    = work_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_seq_shift_rotate_unit.sv
// Self-checking bench for seq_shift_rotate_unit: a STEP=1 and a STEP=4 instance are checked
// against a whole-amount arithmetic reference model with directed and random requests.
module tb_seq_shift_rotate_unit;

    logic        clk = 1'b0;
    logic        Clear = 1'b1;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [4:0]  amt = 5'd0;

    logic        busy1, done1, carry1;
    logic [31:0] result1;
    logic        busy4, done4, carry4;
    logic [31:0] result4;

    int checks = 0;
    int errors = 0;

    seq_shift_rotate_unit #(.WIDTH(32), .AMT_W(5), .STEP(1)) u_step1 (
        .clk(clk), .Clear(Clear), .start(start1), .op(op), .a(a), .amt(amt),
        .busy(busy1), .done(done1), .result(result1), .carry_out(carry1)
    );

    seq_shift_rotate_unit #(.WIDTH(32), .AMT_W(5), .STEP(4)) u_step4 (
        .clk(clk), .Clear(Clear), .start(start4), .op(op), .a(a), .amt(amt),
        .busy(busy4), .done(done4), .result(result4), .carry_out(carry4)
    );

    always #5 clk = ~clk;

    // Whole-amount reference: returns {carry, result}, computed directly from the op definitions.
    function automatic logic [32:0] refModel(input logic [31:0] av, input logic [2:0] opv, input int k);
        logic [31:0] r;
        logic [63:0] dbl;
        logic        c;
        r = av;
        c = 1'b0;
        if (k != 0 && opv <= 3'd4) begin
            case (opv)
                3'd0: begin r = av >> k;                     c = av[k-1];  end
                3'd1: begin r = $unsigned($signed(av) >>> k); c = av[k-1];  end
                3'd2: begin r = av << k;                     c = av[32-k]; end
                3'd3: begin dbl = {av, av} >> k; r = dbl[31:0];  c = r[31]; end
                default: begin dbl = {av, av} << k; r = dbl[63:32]; c = r[0]; end
            endcase
        end
        return {c, r};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issues one request on the selected instance and checks latency, result and carry.
    task automatic applyStimulus(input int sel, input logic [31:0] a_i, input logic [2:0] op_i,
                                 input int amt_i, input string tag);
        logic [32:0] exp;
        int          lat;
        int          step;
        int          cycles;
        logic        got;
        step = (sel == 0) ? 1 : 4;
        exp  = refModel(a_i, op_i, amt_i);
        lat  = (amt_i == 0 || op_i > 3'd4) ? 0 : (amt_i + step - 1) / step;
        a    = a_i;
        op   = op_i;
        amt  = 5'(amt_i);
        if (sel == 0) start1 = 1'b1;
        else          start4 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        a      = $urandom;
        op     = 3'($urandom);
        amt    = 5'($urandom);
        cycles = 0;
        if (lat > 0) checkOutput({tag, ".busy"}, 64'((sel == 0) ? busy1 : busy4), 64'd1);
        got = (sel == 0) ? done1 : done4;
        while (!got && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            got = (sel == 0) ? done1 : done4;
        end
        checkOutput({tag, ".latency"}, 64'(cycles), 64'(lat));
        checkOutput({tag, ".result"}, 64'((sel == 0) ? result1 : result4), 64'(exp[31:0]));
        checkOutput({tag, ".carry"}, 64'((sel == 0) ? carry1 : carry4), 64'(exp[32]));
    endtask

    // One idle cycle after done: done must drop and the result must hold.
    task automatic idleCheck(input int sel, input logic [31:0] held, input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, ".idle_done"}, 64'((sel == 0) ? done1 : done4), 64'd0);
        checkOutput({tag, ".idle_busy"}, 64'((sel == 0) ? busy1 : busy4), 64'd0);
        checkOutput({tag, ".hold"}, 64'((sel == 0) ? result1 : result4), 64'(held));
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rop;
        int          ramt;
        int          sel;
        int          cycles;
        logic        seen_done;
        logic [32:0] exp;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.busy1", 64'(busy1), 64'd0);
        checkOutput("reset.done1", 64'(done1), 64'd0);
        checkOutput("reset.result1", 64'(result1), 64'd0);
        checkOutput("reset.carry1", 64'(carry1), 64'd0);
        checkOutput("reset.busy4", 64'(busy4), 64'd0);
        checkOutput("reset.result4", 64'(result4), 64'd0);
        Clear = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(0, 32'd30, 3'd4, 5, "rol5");
        checkOutput("rol5.value", 64'(result1), 64'h3C0);
        idleCheck(0, 32'h3C0, "rol5");

        applyStimulus(0, 32'h80000001, 3'd3, 1, "ror1");
        applyStimulus(0, 32'h80000001, 3'd2, 1, "shl1_b2b");
        checkOutput("shl1.value", 64'(result1), 64'h2);
        idleCheck(0, 32'h2, "shl1");

        applyStimulus(0, 32'hF0000000, 3'd1, 4, "shra4");
        checkOutput("shra4.value", 64'(result1), 64'hFF000000);
        applyStimulus(0, 32'hF0000000, 3'd0, 4, "shr4");
        applyStimulus(0, 32'h1234ABCD, 3'd2, 0, "amt0");
        applyStimulus(0, 32'h1234ABCD, 3'd7, 9, "illegal");
        checkOutput("illegal.value", 64'(result1), 64'h1234ABCD);
        idleCheck(0, 32'h1234ABCD, "illegal");

        // A start pulsed while busy must be ignored.
        exp    = refModel(32'hDEADBEEF, 3'd3, 20);
        a      = 32'hDEADBEEF;
        op     = 3'd3;
        amt    = 5'd20;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a      = 32'h55555555;
        op     = 3'd0;
        amt    = 5'd1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1    = 1'b0;
        cycles    = 4;
        seen_done = done1;
        while (!seen_done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            seen_done = done1;
        end
        checkOutput("ignore.latency", 64'(cycles), 64'd20);
        checkOutput("ignore.result", 64'(result1), 64'(exp[31:0]));
        checkOutput("ignore.carry", 64'(carry1), 64'(exp[32]));
        idleCheck(0, exp[31:0], "ignore");

        // Clear mid-operation aborts and no done follows.
        a      = 32'hFFFFFFFF;
        op     = 3'd2;
        amt    = 5'd20;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        Clear = 1'b1;
        #1;
        checkOutput("abort.busy", 64'(busy1), 64'd0);
        checkOutput("abort.done", 64'(done1), 64'd0);
        checkOutput("abort.result", 64'(result1), 64'd0);
        checkOutput("abort.carry", 64'(carry1), 64'd0);
        Clear     = 1'b0;
        seen_done = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | done1;
        end
        checkOutput("abort.no_done", 64'(seen_done), 64'd0);

        applyStimulus(1, 32'h12345678, 3'd4, 31, "s4_rol31");
        checkOutput("s4_rol31.value", 64'(result4), 64'h091A2B3C);
        idleCheck(1, 32'h091A2B3C, "s4_rol31");
        applyStimulus(1, 32'h12345678, 3'd4, 6, "s4_rol6");
        applyStimulus(1, 32'h80000001, 3'd0, 3, "s4_shr3_b2b");
        idleCheck(1, 32'h10000000, "s4_shr3");

        for (int i = 0; i < 80; i++) begin
            sel  = (i / 10) % 2;
            ra   = $urandom;
            rop  = 3'($urandom_range(0, 7));
            ramt = $urandom_range(0, 31);
            exp  = refModel(ra, rop, ramt);
            applyStimulus(sel, ra, rop, ramt, "rand");
            if ($urandom_range(0, 1) == 1) idleCheck(sel, exp[31:0], "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
